// File: rtl/bt_pipe_pkg.sv
// -----------------------------------------------------------------------------
// bt_pipe_pkg
// Shared definitions for the block-throttled pipe-out buffer.
//   EP_WIDTH       : width of the words presented to the pipe-out endpoint.
//   OVF_CNT_WIDTH  : width of the saturating dropped-write counter.
//   status_word_t  : 32-bit wire-out layout carrying fill level and sticky
//                    error flags, plus a helper to pack it.
// -----------------------------------------------------------------------------
package bt_pipe_pkg;

    localparam int EP_WIDTH      = 16;
    localparam int OVF_CNT_WIDTH = 16;

    // Fill level field is wide enough for the largest legal depth (2**14).
    localparam int STATUS_FILL_W = 15;

    typedef struct packed {
        logic                     underflow;
        logic                     block_err;
        logic [14:0]              reserved;
        logic [STATUS_FILL_W-1:0] fill;
    } status_word_t;

    function automatic status_word_t pack_status(
        input logic                     underflow,
        input logic                     block_err,
        input logic [STATUS_FILL_W-1:0] fill
    );
        status_word_t s;
        s.underflow = underflow;
        s.block_err = block_err;
        s.reserved  = '0;
        s.fill      = fill;
        return s;
    endfunction

endpackage

// File: rtl/bt_fifo_ram.sv
// -----------------------------------------------------------------------------
// bt_fifo_ram
// Simple dual-port RAM: one write port, one registered read port. Written to
// infer block RAM, so contents and the read register have no reset.
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   re     : read enable; rdata updates only when set, otherwise holds
//   raddr  : read address
//   rdata  : registered read data
// -----------------------------------------------------------------------------
module bt_fifo_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bt_pipe_out_buffer.sv
// -----------------------------------------------------------------------------
// bt_pipe_out_buffer
// FIFO buffer feeding a FrontPanel block-throttled pipe-out endpoint.
//   ti_clk         : host-interface clock
//   rst_n          : asynchronous active-low reset
//   clear          : synchronous flush of FIFO, counters and flags
//   wr_en/wr_data  : producer write strobe and tag word
//   full           : FIFO holds 2**DEPTH_LOG2 words
//   ep_read        : endpoint read strobe (data appears one cycle later)
//   ep_blockstrobe : endpoint start-of-block pulse
//   ep_datain      : word presented to the endpoint
//   ep_ready       : a full block (BLOCK_WORDS) can be drained
//   fill_level     : current word count
//   overflow_cnt   : saturating count of dropped writes
//   underflow      : sticky, read attempted while empty
//   block_err      : sticky, more than BLOCK_WORDS reads in one block
// -----------------------------------------------------------------------------
module bt_pipe_out_buffer
    import bt_pipe_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int BLOCK_WORDS = 256
) (
    input  logic                     ti_clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [EP_WIDTH-1:0]      wr_data,
    output logic                     full,
    input  logic                     ep_read,
    input  logic                     ep_blockstrobe,
    output logic [EP_WIDTH-1:0]      ep_datain,
    output logic                     ep_ready,
    output logic [DEPTH_LOG2:0]      fill_level,
    output logic [OVF_CNT_WIDTH-1:0] overflow_cnt,
    output logic                     underflow,
    output logic                     block_err
);

    localparam int BCNT_W = $clog2(BLOCK_WORDS) + 1;

    localparam logic [DEPTH_LOG2:0]   DEPTH_C   = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0]   BLOCK_C   = (DEPTH_LOG2+1)'(BLOCK_WORDS);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [BCNT_W-1:0]     BLK_LIMIT = BCNT_W'(BLOCK_WORDS);
    localparam logic [BCNT_W-1:0]     BLK_ONE   = BCNT_W'(1);

    function automatic logic [OVF_CNT_WIDTH-1:0] sat_inc(
        input logic [OVF_CNT_WIDTH-1:0] v
    );
        return (&v) ? v : v + OVF_CNT_WIDTH'(1);
    endfunction

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_next;
    logic [BCNT_W-1:0]     blk_cnt;
    logic                  zero_out;
    logic [EP_WIDTH-1:0]   ram_q;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;

    assign full       = (count == DEPTH_C);
    assign empty      = (count == '0);
    assign fill_level = count;

    // A write is judged against the current count only, so a same-cycle
    // read never rescues a write into a full FIFO.
    assign wr_acc = wr_en && !full && !clear;
    assign rd_acc = ep_read && !empty && !clear;

    always_comb begin
        count_next = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    bt_fifo_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (EP_WIDTH)
    ) u_ram (
        .clk   (ti_clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    // The RAM read register has no reset, so the endpoint sees zero after
    // reset, clear or an empty read until the next real read lands.
    assign ep_datain = zero_out ? '0 : ram_q;

    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            ep_ready     <= 1'b0;
            overflow_cnt <= '0;
            underflow    <= 1'b0;
            block_err    <= 1'b0;
            blk_cnt      <= '0;
            zero_out     <= 1'b1;
        end else if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            ep_ready     <= 1'b0;
            overflow_cnt <= '0;
            underflow    <= 1'b0;
            block_err    <= 1'b0;
            blk_cnt      <= '0;
            zero_out     <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count    <= count_next;
            ep_ready <= (count_next >= BLOCK_C);

            if (wr_en && full) begin
                overflow_cnt <= sat_inc(overflow_cnt);
            end

            if (ep_read) begin
                zero_out <= empty;
                if (empty) begin
                    underflow <= 1'b1;
                end
            end

            // Every read attempt counts toward the block, accepted or not.
            if (ep_blockstrobe) begin
                blk_cnt <= ep_read ? BLK_ONE : '0;
            end else if (ep_read) begin
                if (blk_cnt == BLK_LIMIT) begin
                    block_err <= 1'b1;
                    blk_cnt   <= BLK_ONE;
                end else begin
                    blk_cnt <= blk_cnt + BLK_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_bt_pipe_out_buffer.sv
module tb_bt_pipe_out_buffer;

    logic        ti_clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        full;
    logic        ep_read;
    logic        ep_blockstrobe;
    logic [15:0] ep_datain;
    logic        ep_ready;
    logic [10:0] fill_level;
    logic [15:0] overflow_cnt;
    logic        underflow;
    logic        block_err;

    int checks   = 0;
    int failures = 0;

    always #5 ti_clk = ~ti_clk;

    bt_pipe_out_buffer #(
        .DEPTH_LOG2  (10),
        .BLOCK_WORDS (256)
    ) dut (
        .ti_clk         (ti_clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .full           (full),
        .ep_read        (ep_read),
        .ep_blockstrobe (ep_blockstrobe),
        .ep_datain      (ep_datain),
        .ep_ready       (ep_ready),
        .fill_level     (fill_level),
        .overflow_cnt   (overflow_cnt),
        .underflow      (underflow),
        .block_err      (block_err)
    );

    typedef struct {
        logic        clr;
        logic        wr;
        logic [15:0] d;
        logic        rd;
        logic        bs;
        logic [15:0] e_dout;
        logic [10:0] e_fill;
        logic        e_ready;
        logic        e_uf;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Apply one cycle of inputs; returns 1 time unit after the rising edge.
    task automatic cyc(input logic c, input logic w, input logic [15:0] d,
                       input logic r, input logic b);
        clear          = c;
        wr_en          = w;
        wr_data        = d;
        ep_read        = r;
        ep_blockstrobe = b;
        @(posedge ti_clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        //            clr   wr    data      rd    bs    dout      fill   rdy   uf
        tbl[0]  = '{1'b0, 1'b1, 16'h1111, 1'b0, 1'b0, 16'h0000, 11'd1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 16'h0000, 11'd2, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1111, 11'd1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1111, 11'd1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 16'h3333, 1'b1, 1'b0, 16'h2222, 11'd1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h3333, 11'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 11'd0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 11'd0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 16'h9999, 1'b0, 1'b0, 16'h0000, 11'd0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 16'h4444, 1'b0, 1'b0, 16'h0000, 11'd1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h4444, 11'd0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h4444, 11'd0, 1'b0, 1'b0};

        rst_n          = 1'b0;
        clear          = 1'b0;
        wr_en          = 1'b0;
        wr_data        = 16'h0000;
        ep_read        = 1'b0;
        ep_blockstrobe = 1'b0;
        repeat (3) @(posedge ti_clk);
        #1;
        chk("rst_datain",    32'(ep_datain),    32'h0);
        chk("rst_fill",      32'(fill_level),   32'h0);
        chk("rst_ready",     32'(ep_ready),     32'h0);
        chk("rst_full",      32'(full),         32'h0);
        chk("rst_ovf",       32'(overflow_cnt), 32'h0);
        chk("rst_underflow", 32'(underflow),    32'h0);
        chk("rst_block_err", 32'(block_err),    32'h0);
        rst_n = 1'b1;
        idle();

        // Short directed table
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].clr, tbl[i].wr, tbl[i].d, tbl[i].rd, tbl[i].bs);
            chk($sformatf("tbl%0d_datain", i), 32'(ep_datain),  32'(tbl[i].e_dout));
            chk($sformatf("tbl%0d_fill", i),   32'(fill_level), 32'(tbl[i].e_fill));
            chk($sformatf("tbl%0d_ready", i),  32'(ep_ready),   32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_uf", i),     32'(underflow),  32'(tbl[i].e_uf));
        end

        // ep_ready threshold at one block
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 255; i++) cyc(1'b0, 1'b1, 16'(i), 1'b0, 1'b0);
        chk("thr_fill255",  32'(fill_level), 32'd255);
        chk("thr_ready255", 32'(ep_ready),   32'd0);
        cyc(1'b0, 1'b1, 16'h00FF, 1'b0, 1'b0);
        chk("thr_fill256",  32'(fill_level), 32'd256);
        chk("thr_ready256", 32'(ep_ready),   32'd1);

        // One full block drained
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 256; i++) begin
            cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
            chk($sformatf("blk_data%0d", i), 32'(ep_datain), 32'(i));
        end
        idle();
        chk("blk_fill",  32'(fill_level), 32'd0);
        chk("blk_ready", 32'(ep_ready),   32'd0);
        chk("blk_err",   32'(block_err),  32'd0);

        // Fill to capacity, then overflow
        for (int i = 0; i < 1024; i++) cyc(1'b0, 1'b1, 16'(16'h1000 + i), 1'b0, 1'b0);
        chk("cap_full", 32'(full),       32'd1);
        chk("cap_fill", 32'(fill_level), 32'd1024);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0);
        chk("ovf_cnt",  32'(overflow_cnt), 32'd3);
        chk("ovf_full", 32'(full),         32'd1);
        chk("ovf_fill", 32'(fill_level),   32'd1024);
        for (int i = 0; i < 1024; i++) begin
            cyc(1'b0, 1'b0, 16'h0000, 1'b1, (i % 256) == 0);
            chk($sformatf("drain_data%0d", i), 32'(ep_datain), 32'(16'h1000 + i));
        end
        chk("drain_fill", 32'(fill_level), 32'd0);
        chk("drain_full", 32'(full),       32'd0);
        chk("drain_berr", 32'(block_err),  32'd0);

        // Read while empty
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        chk("uf_flag",   32'(underflow),  32'd1);
        chk("uf_datain", 32'(ep_datain),  32'h0);
        chk("uf_fill",   32'(fill_level), 32'd0);
        repeat (3) idle();
        chk("uf_sticky", 32'(underflow),  32'd1);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        chk("uf_clear",  32'(underflow),    32'd0);
        chk("ovf_clear", 32'(overflow_cnt), 32'd0);

        // Steady-state write+read at count 10 across pointer wrap
        cyc(1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0);
        for (int k = 0; k < 1010; k++) cyc(1'b0, 1'b1, 16'(16'hA000 + k), 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk("wrap_prime_fill", 32'(fill_level), 32'd0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 16'(16'h2000 + i), 1'b0, 1'b0);
        chk("wrap_fill10", 32'(fill_level), 32'd10);
        for (int k = 0; k < 50; k++) begin
            cyc(1'b0, 1'b1, 16'(16'h2000 + 10 + k), 1'b1, 1'b0);
            chk($sformatf("wrap_data%0d", k), 32'(ep_datain),  32'(16'h2000 + k));
            chk($sformatf("wrap_fill%0d", k), 32'(fill_level), 32'd10);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
            chk($sformatf("wrap_tail%0d", i), 32'(ep_datain), 32'(16'h2000 + 50 + i));
        end
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);

        // Block overrun then mid-stream clear
        for (int i = 0; i < 600; i++) cyc(1'b0, 1'b1, 16'(16'h3000 + i), 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk("berr_256", 32'(block_err), 32'd0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk("berr_257",   32'(block_err),  32'd1);
        chk("berr_data",  32'(ep_datain),  32'(16'h3000 + 256));
        chk("berr_fill",  32'(fill_level), 32'd343);
        chk("berr_ready", 32'(ep_ready),   32'd1);
        cyc(1'b1, 1'b1, 16'h5555, 1'b1, 1'b0);
        chk("clr_fill",   32'(fill_level),   32'd0);
        chk("clr_ready",  32'(ep_ready),     32'd0);
        chk("clr_ovf",    32'(overflow_cnt), 32'd0);
        chk("clr_uf",     32'(underflow),    32'd0);
        chk("clr_berr",   32'(block_err),    32'd0);
        chk("clr_datain", 32'(ep_datain),    32'h0);
        idle();
        chk("clr_ready_hold", 32'(ep_ready),   32'd0);
        chk("clr_fill_hold",  32'(fill_level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
